udp_video_receiver: RTL and testbench
=====================================

// Module: udp_video_receiver
// PURPOSE
//   Receive-side counterpart of the video UDP packetiser. Each UDP payload carries a
//   2-byte big-endian line number followed by LINE_BYTES pixel bytes.
//   - Parses that payload from the UDP stack's byte stream.
//   - Re-packs pixel bytes into 16-bit big-endian pixels.
//   - Emits line and frame markers for a downstream frame-buffer writer.
//   - Single clock domain (udp_clk). A CDC FIFO downstream handles any clock crossing.
// PARAMETERS
//   LINE_BYTES  1280  pixel bytes per packet (payload excluding header); must be even
//   V_DISP      480   lines per frame; valid line numbers are 1..V_DISP
// PORTS
//   udp_clk            in   1   ethernet/UDP clock
//   rst_n              in   1   asynchronous active-low reset
//   udp_rx_data        in   8   UDP payload byte
//   udp_rx_data_valid  in   1   payload byte valid; high contiguously for one packet
//   pixel_data         out  16  reassembled pixel {first byte, second byte}
//   pixel_valid        out  1   pixel_data valid, 1-cycle pulse per pixel
//   line_num           out  16  line number of the current/last accepted packet
//   sof                out  1   pulse with the first pixel of line 1
//   eol                out  1   pulse when a packet completes with exactly LINE_BYTES bytes
//   eof                out  1   pulse together with eol when line_num == V_DISP
//   pkt_err            out  1   pulse when a packet is dropped (runt/overlong/bad line)
//   seq_err            out  1   pulse when an accepted line_num != expected line
// BEHAVIOUR
//   Reset values
//   - All outputs are 0.
//   - The FSM resets to DROP, so a packet already in flight at reset release is
//     discarded. Internal expected line resets to 1.
//   FSM states: IDLE, HDR_LO, PAYLOAD, DROP
//   - IDLE
//     - valid=1: latch byte as hdr[15:8] -> HDR_LO.
//   - HDR_LO
//     - valid=1: hdr[7:0] = byte.
//       - If hdr is 0 or > V_DISP: pkt_err, -> DROP.
//       - Otherwise: line_num <= hdr, byte_cnt <= 0, -> PAYLOAD.
//       - If hdr != expected: seq_err, but the line is still accepted.
//     - valid=0: runt packet. pkt_err, -> IDLE.
//   - PAYLOAD
//     - valid=1, byte_cnt < LINE_BYTES:
//       - Even byte_cnt: store the byte as the high byte.
//       - Odd byte_cnt: pixel_data <= {hi, byte}; pixel_valid=1 on the next edge
//         (1-cycle latency from the low byte).
//       - byte_cnt++ in both cases.
//     - valid=1, byte_cnt == LINE_BYTES: overlong packet. pkt_err, -> DROP.
//       Pixels already emitted are not retracted; eol is not asserted.
//     - valid=0, byte_cnt == LINE_BYTES:
//       - eol=1; eof=1 if line_num == V_DISP.
//       - expected <= (line_num == V_DISP) ? 1 : line_num+1.
//       - -> IDLE.
//     - valid=0, byte_cnt < LINE_BYTES: short packet. pkt_err, no eol, -> IDLE.
//   - DROP
//     - Ignore bytes until valid=0, then -> IDLE. No pixel output while in DROP.
//   Timing and widths
//   - sof is coincident with the first pixel_valid of a packet whose line_num == 1.
//   - eol/eof/pkt_err/seq_err are registered 1-cycle pulses, asserted the cycle after
//     the triggering input.
//   - byte_cnt is 16 bits wide and saturates at LINE_BYTES (no wrap).
//   - Back-to-back packets: valid low for a single cycle between packets is sufficient.
//   - There is no back-pressure. The downstream sink must accept 1 pixel per 2 clocks.
// CONFIGURATION
//   UDP_RX_STATS_EN
//   - Defined: adds outputs stat_pkts[31:0] (packets completing with eol) and
//     stat_drops[31:0] (pkt_err count). Both reset to 0 and wrap at 2^32.
//   - Undefined: these ports and counters do not exist. All other behaviour is identical.
// TESTING  (LINE_BYTES=8, V_DISP=4)
//   1. Good line: bytes 00 01 11 22 33 44 55 66 77 88 -> 4 pixels 1122,3344,5566,7788;
//      sof with pixel 1122; eol; no errors.
//   2. Full frame: lines 1..4 back-to-back with a 1-cycle gap -> 16 pixels;
//      eof with line 4's eol; expected wraps to 1.
//   3. Short line: 00 02 + 6 bytes -> 3 pixels, pkt_err, no eol.
//      Overlong: 00 02 + 10 bytes -> pkt_err, no eol.
//   4. Bad header: 00 00 and 00 05 + 8 bytes -> pkt_err, no pixel_valid.
//      Runt: a single byte -> pkt_err.
//   5. Sequence gap: line 1 then line 3 -> seq_err pulse on line 3's header; its pixels
//      are still output.
//   6. Reset mid-PAYLOAD with valid held high -> outputs 0; the rest of the packet is
//      dropped; the next packet is parsed normally. With UDP_RX_STATS_EN: the counts
//      match tests 1-5.

Source files
------------

// File: rtl/udp_video_receiver.sv
// Parses UDP video payloads (2-byte big-endian line number + LINE_BYTES pixel bytes)
// into 16-bit pixels with sof/eol/eof markers. Optional counters: UDP_RX_STATS_EN.
module udp_video_receiver #(
    parameter int LINE_BYTES = 1280,
    parameter int V_DISP     = 480
) (
    input  logic        udp_clk,
    input  logic        rst_n,
    input  logic [7:0]  udp_rx_data,
    input  logic        udp_rx_data_valid,
    output logic [15:0] pixel_data,
    output logic        pixel_valid,
    output logic [15:0] line_num,
    output logic        sof,
    output logic        eol,
    output logic        eof,
    output logic        pkt_err,
    output logic        seq_err
`ifdef UDP_RX_STATS_EN
    ,
    output logic [31:0] stat_pkts,
    output logic [31:0] stat_drops
`endif
);

    localparam logic [15:0] LB = 16'(LINE_BYTES);
    localparam logic [15:0] VD = 16'(V_DISP);

    typedef enum logic [1:0] {IDLE, HDR_LO, PAYLOAD, DROP} state_t;

    state_t      state, state_next;
    logic [7:0]  hdr_hi;
    logic [7:0]  pix_hi;
    logic [15:0] byte_cnt;
    logic [15:0] expected;
    logic [15:0] hdr;

    logic load_hdr_hi, accept_hdr, store_hi, emit_pix, line_done, err_d, seq_d, sof_d;

    assign hdr = {hdr_hi, udp_rx_data};

    always_ff @(posedge udp_clk or negedge rst_n) begin
        if (!rst_n) state <= DROP;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        load_hdr_hi = 1'b0;
        accept_hdr  = 1'b0;
        store_hi    = 1'b0;
        emit_pix    = 1'b0;
        line_done   = 1'b0;
        err_d       = 1'b0;
        seq_d       = 1'b0;
        sof_d       = 1'b0;
        case (state)
            IDLE: begin
                if (udp_rx_data_valid) begin
                    load_hdr_hi = 1'b1;
                    state_next  = HDR_LO;
                end
            end
            HDR_LO: begin
                if (!udp_rx_data_valid) begin
                    err_d      = 1'b1;
                    state_next = IDLE;
                end else if (hdr == 16'd0 || hdr > VD) begin
                    err_d      = 1'b1;
                    state_next = DROP;
                end else begin
                    // Out-of-sequence lines are flagged but still written.
                    accept_hdr = 1'b1;
                    seq_d      = (hdr != expected);
                    state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (udp_rx_data_valid) begin
                    if (byte_cnt < LB) begin
                        if (byte_cnt[0]) begin
                            emit_pix = 1'b1;
                            sof_d    = (byte_cnt == 16'd1) && (line_num == 16'd1);
                        end else begin
                            store_hi = 1'b1;
                        end
                    end else begin
                        err_d      = 1'b1;
                        state_next = DROP;
                    end
                end else begin
                    if (byte_cnt == LB) line_done = 1'b1;
                    else                err_d     = 1'b1;
                    state_next = IDLE;
                end
            end
            DROP: begin
                if (!udp_rx_data_valid) state_next = IDLE;
            end
            default: state_next = DROP;
        endcase
    end

    always_ff @(posedge udp_clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            line_num    <= '0;
            sof         <= 1'b0;
            eol         <= 1'b0;
            eof         <= 1'b0;
            pkt_err     <= 1'b0;
            seq_err     <= 1'b0;
            hdr_hi      <= '0;
            pix_hi      <= '0;
            byte_cnt    <= '0;
            expected    <= 16'd1;
        end else begin
            pixel_valid <= emit_pix;
            sof         <= sof_d;
            eol         <= line_done;
            eof         <= line_done && (line_num == VD);
            pkt_err     <= err_d;
            seq_err     <= seq_d;
            if (load_hdr_hi) hdr_hi <= udp_rx_data;
            if (accept_hdr) begin
                line_num <= hdr;
                byte_cnt <= '0;
            end else if (store_hi || emit_pix) begin
                byte_cnt <= byte_cnt + 16'd1;
            end
            if (store_hi) pix_hi <= udp_rx_data;
            if (emit_pix) pixel_data <= {pix_hi, udp_rx_data};
            if (line_done) expected <= (line_num == VD) ? 16'd1 : line_num + 16'd1;
        end
    end

`ifdef UDP_RX_STATS_EN
    always_ff @(posedge udp_clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pkts  <= '0;
            stat_drops <= '0;
        end else begin
            if (line_done) stat_pkts  <= stat_pkts + 32'd1;
            if (err_d)     stat_drops <= stat_drops + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_udp_video_receiver.sv
// Directed bench for udp_video_receiver with LINE_BYTES=8, V_DISP=4.
module tb_udp_video_receiver;

    localparam int LB = 8;
    localparam int VD = 4;

    logic        udp_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  udp_rx_data = '0;
    logic        udp_rx_data_valid = 1'b0;
    logic [15:0] pixel_data;
    logic        pixel_valid;
    logic [15:0] line_num;
    logic        sof, eol, eof, pkt_err, seq_err;
`ifdef UDP_RX_STATS_EN
    logic [31:0] stat_pkts, stat_drops;
`endif

    always #5 udp_clk = ~udp_clk;

    udp_video_receiver #(.LINE_BYTES(LB), .V_DISP(VD)) dut (
        .udp_clk(udp_clk),
        .rst_n(rst_n),
        .udp_rx_data(udp_rx_data),
        .udp_rx_data_valid(udp_rx_data_valid),
        .pixel_data(pixel_data),
        .pixel_valid(pixel_valid),
        .line_num(line_num),
        .sof(sof),
        .eol(eol),
        .eof(eof),
        .pkt_err(pkt_err),
`ifdef UDP_RX_STATS_EN
        .seq_err(seq_err),
        .stat_pkts(stat_pkts),
        .stat_drops(stat_drops)
`else
        .seq_err(seq_err)
`endif
    );

    // Output monitor: records pixels and pulse counts on the falling edge.
    logic [15:0] pix_q[$];
    logic [15:0] sof_pix = '0;
    int n_sof = 0, n_eol = 0, n_eof = 0, n_err = 0, n_seq = 0;
    int n_sof_alone = 0, n_eof_alone = 0;

    always @(negedge udp_clk) begin
        if (pixel_valid) pix_q.push_back(pixel_data);
        if (sof) begin
            n_sof++;
            sof_pix = pixel_data;
            if (!pixel_valid) n_sof_alone++;
        end
        if (eol) n_eol++;
        if (eof) begin
            n_eof++;
            if (!eol) n_eof_alone++;
        end
        if (pkt_err) n_err++;
        if (seq_err) n_seq++;
    end

    int checks = 0;
    int failures = 0;
    int b_pix, b_sof, b_eol, b_eof, b_err, b_seq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_pix = pix_q.size();
        b_sof = n_sof; b_eol = n_eol; b_eof = n_eof; b_err = n_err; b_seq = n_seq;
    endtask

    task automatic check_pkt(input string tag, input int pix, input int s, input int el,
                             input int ef, input int er, input int sq);
        check({tag, "_npix"}, 32'(pix_q.size() - b_pix), 32'(pix));
        check({tag, "_sof"},  32'(n_sof - b_sof), 32'(s));
        check({tag, "_eol"},  32'(n_eol - b_eol), 32'(el));
        check({tag, "_eof"},  32'(n_eof - b_eof), 32'(ef));
        check({tag, "_pkterr"}, 32'(n_err - b_err), 32'(er));
        check({tag, "_seqerr"}, 32'(n_seq - b_seq), 32'(sq));
    endtask

    // Pixel k of a packet whose payload byte j is start + j*step.
    task automatic check_pix(input string tag, input int base, input int n,
                             input int start, input int step);
        for (int k = 0; k < n; k++) begin
            logic [15:0] e;
            e = {8'(start + 2 * k * step), 8'(start + (2 * k + 1) * step)};
            check({tag, "_pix"}, 32'(pix_q[base + k]), 32'(e));
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge udp_clk);
        udp_rx_data = b;
        udp_rx_data_valid = 1'b1;
    endtask

    task automatic gap();
        @(negedge udp_clk);
        udp_rx_data = '0;
        udp_rx_data_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [15:0] hdr, input int n, input int start, input int step);
        send_byte(hdr[15:8]);
        send_byte(hdr[7:0]);
        for (int j = 0; j < n; j++) send_byte(8'(start + j * step));
        gap();
    endtask

    task automatic settle();
        repeat (3) @(negedge udp_clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge udp_clk);
        #1;
        check("rst_outputs", {15'd0, pixel_valid, sof, eol, eof, pkt_err, seq_err, 11'd0},
              32'd0);
        check("rst_pixel_data", 32'(pixel_data), 32'd0);
        check("rst_line_num", 32'(line_num), 32'd0);
        @(negedge udp_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge udp_clk);

        // Full frame, lines 1..4 with a one-cycle gap
        snap();
        for (int l = 1; l <= VD; l++) send_pkt(16'(l), LB, l * 16, 1);
        settle();
        check_pkt("frame", 16, 1, 4, 1, 0, 0);
        for (int l = 0; l < VD; l++) check_pix("frame", b_pix + 4 * l, 4, (l + 1) * 16, 1);
        check("frame_sof_pix", 32'(sof_pix), 32'h1011);
        check("frame_line_num", 32'(line_num), 32'd4);

        // Good line 1 after wrap: no seq_err
        snap();
        send_pkt(16'd1, LB, 'h11, 'h11);
        settle();
        check_pkt("good", 4, 1, 1, 0, 0, 0);
        check("good_pix0", 32'(pix_q[b_pix]), 32'h1122);
        check("good_pix3", 32'(pix_q[b_pix + 3]), 32'h7788);
        check("good_sof_pix", 32'(sof_pix), 32'h1122);
        check("good_line_num", 32'(line_num), 32'd1);

        // Line 3 after line 1: seq_err, pixels still delivered
        snap();
        send_pkt(16'd3, LB, 'h30, 1);
        settle();
        check_pkt("seqgap", 4, 0, 1, 0, 0, 1);
        check_pix("seqgap", b_pix, 4, 'h30, 1);
        check("seqgap_line_num", 32'(line_num), 32'd3);

        // Short line 2 (expected is 4, so also out of sequence)
        snap();
        send_pkt(16'd2, 6, 'hA0, 1);
        settle();
        check_pkt("short", 3, 0, 0, 0, 1, 1);
        check_pix("short", b_pix, 3, 'hA0, 1);

        // Overlong line 2: first 4 pixels stand, no eol
        snap();
        send_pkt(16'd2, 10, 'hA0, 1);
        settle();
        check_pkt("overlong", 4, 0, 0, 0, 1, 1);
        check_pix("overlong", b_pix, 4, 'hA0, 1);

        // Bad headers and a runt
        snap();
        send_pkt(16'd0, LB, 'h50, 1);
        settle();
        check_pkt("hdr0", 0, 0, 0, 0, 1, 0);
        snap();
        send_pkt(16'd5, LB, 'h50, 1);
        settle();
        check_pkt("hdr5", 0, 0, 0, 0, 1, 0);
        check("hdr5_line_num", 32'(line_num), 32'd2);
        snap();
        send_byte(8'h00);
        gap();
        settle();
        check_pkt("runt", 0, 0, 0, 0, 1, 0);
`ifdef UDP_RX_STATS_EN
        check("stat_pkts", stat_pkts, 32'd6);
        check("stat_drops", stat_drops, 32'd5);
`endif

        // Reset in the middle of a payload with valid held high
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hC0);
        send_byte(8'hC1);
        send_byte(8'hC2);
        @(negedge udp_clk);
        udp_rx_data = 8'hC3;
        rst_n = 1'b0;
        #1;
        check("midrst_flags", {26'd0, pixel_valid, sof, eol, eof, pkt_err, seq_err}, 32'd0);
        check("midrst_pixel_data", 32'(pixel_data), 32'd0);
        check("midrst_line_num", 32'(line_num), 32'd0);
`ifdef UDP_RX_STATS_EN
        check("midrst_stat_pkts", stat_pkts, 32'd0);
`endif
        snap();
        send_byte(8'hC4);
        send_byte(8'hC5);
        @(negedge udp_clk);
        udp_rx_data = 8'hC6;
        rst_n = 1'b1;
        send_byte(8'hC7);
        send_byte(8'hC8);
        send_byte(8'hC9);
        gap();
        settle();
        check_pkt("dropped", 0, 0, 0, 0, 0, 0);

        snap();
        send_pkt(16'd1, LB, 'hD0, 1);
        settle();
        check_pkt("postrst", 4, 1, 1, 0, 0, 0);
        check_pix("postrst", b_pix, 4, 'hD0, 1);
        check("postrst_line_num", 32'(line_num), 32'd1);
`ifdef UDP_RX_STATS_EN
        check("post_stat_pkts", stat_pkts, 32'd1);
        check("post_stat_drops", stat_drops, 32'd0);
`endif

        check("sof_without_pixel", 32'(n_sof_alone), 32'd0);
        check("eof_without_eol", 32'(n_eof_alone), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
